uart_boot_loader: RTL and testbench

- Sits between the t16450 UART and RAM, upstream of the CPU.
- After reset it programs the UART, then polls it for received bytes.
- It parses a framed binary image and writes the image into RAM as 16-bit words.
- `cpu_hold` keeps the CPU stalled until a frame with a valid checksum has been fully loaded.
- At top level, `uart_*` and `ram_*` are muxed with `memory_io` outputs while `cpu_hold`=1.

---
 rtl/boot_pkg.sv | 33 +++
 rtl/uart_reg_port.sv | 35 +++
 rtl/uart_boot_loader.sv | 151 +++++++++++++++
 tb/tb_uart_boot_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: UART register map, LSR bits and loader state encodings.
package boot_pkg;
  localparam logic [2:0] RBR = 3'd0;
  localparam logic [2:0] DLL = 3'd0;
  localparam logic [2:0] DLM = 3'd1;
  localparam logic [2:0] LCR = 3'd3;
  localparam logic [2:0] LSR = 3'd5;
  localparam int LSR_DR = 0;
  localparam int LSR_OE = 1;
  localparam int LSR_PE = 2;
  localparam int LSR_FE = 3;
  localparam logic [7:0] LCR_DLAB = 8'h80;
  typedef logic [3:0] bus_state_t;
  localparam bus_state_t S_INIT0     = 4'd0;
  localparam bus_state_t S_INIT1     = 4'd1;
  localparam bus_state_t S_INIT2     = 4'd2;
  localparam bus_state_t S_INIT3     = 4'd3;
  localparam bus_state_t S_POLL      = 4'd4;
  localparam bus_state_t S_POLL_WAIT = 4'd5;
  localparam bus_state_t S_READ      = 4'd6;
  localparam bus_state_t S_READ_WAIT = 4'd7;
  localparam bus_state_t S_RAM_WR    = 4'd8;
  localparam bus_state_t S_IDLE      = 4'd9;
  typedef logic [2:0] phase_t;
  localparam phase_t P_SYNC    = 3'd0;
  localparam phase_t P_LEN_LO  = 3'd1;
  localparam phase_t P_LEN_HI  = 3'd2;
  localparam phase_t P_ADDR_LO = 3'd3;
  localparam phase_t P_ADDR_HI = 3'd4;
  localparam phase_t P_DATA_LO = 3'd5;
  localparam phase_t P_DATA_HI = 3'd6;
  localparam phase_t P_CSUM    = 3'd7;
endpackage

// File: rtl/uart_reg_port.sv
// uart_reg_port: one-cycle UART register write, or read with data valid the following cycle.
module uart_reg_port (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       wr,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] uart_rd_data,
  output logic       uart_cs_n,
  output logic       uart_rd_n,
  output logic       uart_wr_n,
  output logic [2:0] uart_addr,
  output logic [7:0] uart_wr_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);
  logic pend_q, pend_d;
  always_comb begin
    pend_d = start & ~wr;
    uart_cs_n = ~start;
    uart_rd_n = ~(start & ~wr);
    uart_wr_n = ~(start & wr);
    uart_addr = start ? addr : 3'd0;
    uart_wr_data = (start & wr) ? wdata : 8'd0;
    busy = pend_q;
    done = (start & wr) | pend_q;
    rdata = pend_q ? uart_rd_data : 8'd0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) pend_q <= 1'b0;
    else pend_q <= pend_d;
  end
endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: programs the UART, parses a framed image and writes it to RAM.
module uart_boot_loader import boot_pkg::*; #(
  parameter logic [15:0] DIVISOR   = 16'd27,
  parameter logic [7:0]  SYNC_BYTE = 8'h55,
  parameter logic [7:0]  LCR_VALUE = 8'h03
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        uart_cs_n,
  output logic        uart_rd_n,
  output logic        uart_wr_n,
  output logic [2:0]  uart_addr,
  output logic [7:0]  uart_wr_data,
  input  logic [7:0]  uart_rd_data,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_we,
  output logic [1:0]  ram_be,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  bus_state_t state_q, state_d;
  phase_t phase_q, phase_d;
  logic [7:0] csum_q, csum_d, lo_q, lo_d;
  logic [15:0] count_q, count_d, base_q, base_d, index_q, index_d, word_q, word_d;
  logic line_err_q, line_err_d, done_q, done_d, error_q, error_d, hold_q, hold_d, live_q;
  logic p_start, p_wr, p_busy, p_done;
  logic [2:0] p_addr;
  logic [7:0] p_wdata, p_rdata;
  uart_reg_port u_port (
    .clk(clk), .reset_n(reset_n), .start(p_start), .wr(p_wr), .addr(p_addr),
    .wdata(p_wdata), .uart_rd_data(uart_rd_data), .uart_cs_n(uart_cs_n),
    .uart_rd_n(uart_rd_n), .uart_wr_n(uart_wr_n), .uart_addr(uart_addr),
    .uart_wr_data(uart_wr_data), .busy(p_busy), .done(p_done), .rdata(p_rdata)
  );
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    csum_d = csum_q;
    lo_d = lo_q;
    count_d = count_q;
    base_d = base_q;
    index_d = index_q;
    word_d = word_q;
    line_err_d = line_err_q;
    done_d = done_q;
    error_d = error_q;
    hold_d = hold_q;
    p_wr = state_q <= S_INIT3;
    p_addr = (state_q == S_INIT0 || state_q == S_INIT3) ? LCR :
             state_q == S_INIT1 ? DLL :
             state_q == S_INIT2 ? DLM :
             state_q == S_POLL  ? LSR : RBR;
    p_wdata = state_q == S_INIT0 ? LCR_DLAB :
              state_q == S_INIT1 ? DIVISOR[7:0] :
              state_q == S_INIT2 ? DIVISOR[15:8] :
              state_q == S_INIT3 ? LCR_VALUE : 8'd0;
    // live_q holds off the first access for one cycle after reset release
    p_start = live_q & ~p_busy & (p_wr | state_q == S_POLL | state_q == S_READ);
    case (state_q)
      S_INIT0, S_INIT1, S_INIT2, S_INIT3: if (p_done) state_d = state_q + 4'd1;
      S_POLL: if (p_start) state_d = S_POLL_WAIT;
      S_POLL_WAIT: if (p_done) begin
        state_d = p_rdata[LSR_DR] ? S_READ : S_POLL;
        line_err_d = line_err_q | (p_rdata[LSR_DR] & |p_rdata[LSR_FE:LSR_OE]);
      end
      S_READ: if (p_start) state_d = S_READ_WAIT;
      S_READ_WAIT: if (p_done) begin
        state_d = S_POLL;
        if (line_err_q) begin
          line_err_d = 1'b0;
          error_d = 1'b1;
          phase_d = P_SYNC;
          csum_d = 8'd0;
        end else begin
          if (phase_q != P_SYNC && phase_q != P_CSUM) csum_d = csum_q + p_rdata;
          case (phase_q)
            P_SYNC: if (p_rdata == SYNC_BYTE) begin
              error_d = 1'b0;
              csum_d = 8'd0;
              phase_d = P_LEN_LO;
            end
            P_LEN_LO: begin count_d[7:0] = p_rdata; phase_d = P_LEN_HI; end
            P_LEN_HI: begin count_d[15:8] = p_rdata; phase_d = P_ADDR_LO; end
            P_ADDR_LO: begin base_d[7:0] = p_rdata; phase_d = P_ADDR_HI; end
            P_ADDR_HI: begin
              base_d[15:8] = p_rdata;
              index_d = 16'd0;
              phase_d = count_q == 16'd0 ? P_CSUM : P_DATA_LO;
            end
            P_DATA_LO: begin lo_d = p_rdata; phase_d = P_DATA_HI; end
            P_DATA_HI: begin word_d = {p_rdata, lo_q}; state_d = S_RAM_WR; end
            default: if (p_rdata == csum_q) begin
              done_d = 1'b1;
              hold_d = 1'b0;
              state_d = S_IDLE;
            end else begin
              error_d = 1'b1;
              phase_d = P_SYNC;
            end
          endcase
        end
      end
      S_RAM_WR: begin
        index_d = index_q + 16'd1;
        phase_d = (index_q + 16'd1 == count_q) ? P_CSUM : P_DATA_LO;
        state_d = S_POLL;
      end
      default: ;
    endcase
    ram_we = state_q == S_RAM_WR;
    ram_be = {2{ram_we}};
    ram_addr = ram_we ? base_q + index_q : 16'd0;
    ram_wdata = ram_we ? word_q : 16'd0;
    cpu_hold = hold_q;
    done = done_q;
    error = error_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_INIT0;
      phase_q <= P_SYNC;
      csum_q <= 8'd0;
      lo_q <= 8'd0;
      count_q <= 16'd0;
      base_q <= 16'd0;
      index_q <= 16'd0;
      word_q <= 16'd0;
      line_err_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      hold_q <= 1'b1;
      live_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      csum_q <= csum_d;
      lo_q <= lo_d;
      count_q <= count_d;
      base_q <= base_d;
      index_q <= index_d;
      word_q <= word_d;
      line_err_q <= line_err_d;
      done_q <= done_d;
      error_q <= error_d;
      hold_q <= hold_d;
      live_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: directed frames through a behavioural UART, checking RAM writes and status.
module tb_uart_boot_loader;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [7:0] uart_rd_data = 8'd0;
  logic uart_cs_n, uart_rd_n, uart_wr_n, ram_we, cpu_hold, done, error;
  logic [2:0] uart_addr;
  logic [7:0] uart_wr_data;
  logic [15:0] ram_addr, ram_wdata;
  logic [1:0] ram_be;
  int tests = 0, fails = 0;
  int popped = 0, inject_at = -1, cyc = 0, we_cnt = 0, acc_cnt = 0;
  bit be_bad = 0, ram_idle_bad = 0;
  logic [7:0] rxq[$];
  logic [15:0] mem [logic [15:0]];
  logic [15:0] we_addr_log[$];
  logic [10:0] wr_log[$];
  int wr_cyc[$];
  logic [2:0] rd_log[$];
  logic [10:0] init_exp[4] = '{11'h380, 11'h01B, 11'h100, 11'h303};

  always #5 clk = ~clk;

  uart_boot_loader dut (
    .clk(clk), .reset_n(reset_n), .uart_cs_n(uart_cs_n), .uart_rd_n(uart_rd_n),
    .uart_wr_n(uart_wr_n), .uart_addr(uart_addr), .uart_wr_data(uart_wr_data),
    .uart_rd_data(uart_rd_data), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_be(ram_be), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  // UART model and bus monitor; read data is presented from mid read cycle onward
  always @(negedge clk) begin
    cyc++;
    if (!uart_cs_n) begin
      acc_cnt++;
      if (!uart_wr_n) begin
        wr_log.push_back({uart_addr, uart_wr_data});
        wr_cyc.push_back(cyc);
      end
      if (!uart_rd_n) begin
        rd_log.push_back(uart_addr);
        if (uart_addr == 3'd5)
          uart_rd_data = rxq.size() == 0 ? 8'h00 : (popped == inject_at ? 8'h09 : 8'h01);
        else if (uart_addr == 3'd0 && rxq.size() != 0) begin
          uart_rd_data = rxq.pop_front();
          popped++;
        end
      end
    end
    if (ram_we) begin
      we_cnt++;
      mem[ram_addr] = ram_wdata;
      we_addr_log.push_back(ram_addr);
      if (ram_be !== 2'b11) be_bad = 1;
    end else if (ram_be !== 2'b00 || ram_addr !== 16'd0 || ram_wdata !== 16'd0) ram_idle_bad = 1;
  end

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    rd_log.delete();
    we_addr_log.delete();
    mem.delete();
    we_cnt = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    rxq.delete();
    inject_at = -1;
    repeat (2) @(negedge clk);
    clear_logs();
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] f[$]);
    int n = 0;
    foreach (f[i]) rxq.push_back(f[i]);
    while (rxq.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rxq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d bytes left unread, required 0", rxq.size());
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({uart_cs_n, uart_rd_n, uart_wr_n, uart_addr, uart_wr_data} !== {3'b111, 3'd0, 8'd0}) begin
      fails++;
      $display("FAIL reset_uart: got cs/rd/wr=%b%b%b addr=%0d data=%h, required 111/0/00", uart_cs_n, uart_rd_n, uart_wr_n, uart_addr, uart_wr_data);
    end
    tests++;
    if ({ram_we, ram_be, ram_addr, ram_wdata} !== 35'd0) begin
      fails++;
      $display("FAIL reset_ram: got we=%b be=%b addr=%h data=%h, required all 0", ram_we, ram_be, ram_addr, ram_wdata);
    end
    tests++;
    if ({cpu_hold, done, error} !== 3'b100) begin
      fails++;
      $display("FAIL reset_status: got hold/done/err=%b%b%b, required 100", cpu_hold, done, error);
    end
    clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic test_init();
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (i >= wr_log.size()) begin
        fails++;
        $display("FAIL init_wr%0d: missing, required %h", i, init_exp[i]);
      end else if (wr_log[i] !== init_exp[i]) begin
        fails++;
        $display("FAIL init_wr%0d: got %h, required %h", i, wr_log[i], init_exp[i]);
      end
    end
    tests++;
    if (wr_log.size() != 4 || wr_cyc[3] - wr_cyc[0] != 3) begin
      fails++;
      $display("FAIL init_consecutive: got %0d writes, required 4 on consecutive cycles", wr_log.size());
    end
    tests++;
    if (rd_log.size() == 0 || rd_log[0] !== 3'd5) begin
      fails++;
      $display("FAIL init_poll: got %0d reads, required LSR polls at addr 5", rd_log.size());
    end
    tests++;
    if (cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL init_hold: got %b, required 1", cpu_hold);
    end
  endtask

  task automatic test_normal_load();
    logic [7:0] f[$];
    int a;
    do_reset();
    f = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h10, 8'h34, 8'h12, 8'h78, 8'h56, 8'h26};
    send(f);
    tests++;
    if (mem[16'h1000] !== 16'h1234 || mem[16'h1001] !== 16'h5678) begin
      fails++;
      $display("FAIL normal_ram: got %h %h, required 1234 5678", mem[16'h1000], mem[16'h1001]);
    end
    tests++;
    if (we_cnt != 2) begin
      fails++;
      $display("FAIL normal_we_count: got %0d, required 2", we_cnt);
    end
    tests++;
    if ({done, cpu_hold, error} !== 3'b100) begin
      fails++;
      $display("FAIL normal_status: got done/hold/err=%b%b%b, required 100", done, cpu_hold, error);
    end
    a = acc_cnt;
    repeat (20) @(negedge clk);
    tests++;
    if (acc_cnt != a) begin
      fails++;
      $display("FAIL normal_idle: got %0d UART accesses in IDLE, required 0", acc_cnt - a);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h10, 8'h34, 8'h12, 8'h78, 8'h56, 8'h27};
    send(f);
    tests++;
    if (we_cnt != 2) begin
      fails++;
      $display("FAIL badcs_we_count: got %0d, required 2", we_cnt);
    end
    tests++;
    if ({error, cpu_hold, done} !== 3'b110) begin
      fails++;
      $display("FAIL badcs_status: got err/hold/done=%b%b%b, required 110", error, cpu_hold, done);
    end
    f = '{8'h55};
    send(f);
    tests++;
    if (error !== 1'b0) begin
      fails++;
      $display("FAIL badcs_sync_clears: got error=%b, required 0", error);
    end
    f = '{8'h02, 8'h00, 8'h00, 8'h10, 8'h34, 8'h12, 8'h78, 8'h56, 8'h26};
    send(f);
    tests++;
    if ({done, error, cpu_hold} !== 3'b100 || we_cnt != 4) begin
      fails++;
      $display("FAIL badcs_retry: got done/err/hold=%b%b%b we=%0d, required 100 we=4", done, error, cpu_hold, we_cnt);
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] f[$];
    do_reset();
    f = '{8'hAA, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h20, 8'h20};
    send(f);
    tests++;
    if (we_cnt != 0 || done !== 1'b1 || error !== 1'b0) begin
      fails++;
      $display("FAIL zero_len: got we=%0d done=%b err=%b, required we=0 done=1 err=0", we_cnt, done, error);
    end
  endtask

  task automatic test_addr_wrap();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h55, 8'h02, 8'h00, 8'hFF, 8'hFF, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    send(f);
    tests++;
    if (we_addr_log.size() != 2 || we_addr_log[0] !== 16'hFFFF || we_addr_log[1] !== 16'h0000) begin
      fails++;
      $display("FAIL wrap_order: got %0d writes, required FFFF then 0000", we_addr_log.size());
    end
    tests++;
    if (mem[16'hFFFF] !== 16'h0001 || mem[16'h0000] !== 16'h0002 || done !== 1'b1) begin
      fails++;
      $display("FAIL wrap_data: got %h %h done=%b, required 0001 0002 done=1", mem[16'hFFFF], mem[16'h0000], done);
    end
  endtask

  task automatic test_line_error();
    logic [7:0] f[$];
    do_reset();
    inject_at = popped + 6;
    f = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
    send(f);
    tests++;
    if ({error, done, cpu_hold} !== 3'b101 || we_cnt != 0) begin
      fails++;
      $display("FAIL line_err: got err/done/hold=%b%b%b we=%0d, required 101 we=0", error, done, cpu_hold, we_cnt);
    end
    f = '{8'h55, 8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'h66};
    send(f);
    tests++;
    if (done !== 1'b1 || error !== 1'b0 || we_cnt != 1 || mem[16'h0000] !== 16'hBBAA) begin
      fails++;
      $display("FAIL line_err_recover: got done=%b err=%b we=%0d ram0=%h, required 1 0 1 BBAA", done, error, we_cnt, mem[16'h0000]);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] f[$];
    do_reset();
    f = '{8'h55, 8'h02, 8'h00};
    send(f);
    reset_n = 1'b0;
    @(negedge clk);
    tests++;
    if ({uart_cs_n, uart_rd_n, uart_wr_n, uart_addr, uart_wr_data, ram_we, ram_be, ram_addr, ram_wdata, cpu_hold, done, error}
        !== {3'b111, 46'd0, 3'b100}) begin
      fails++;
      $display("FAIL midreset_outputs: got cs=%b hold=%b done=%b err=%b we=%b, required 1 1 0 0 0", uart_cs_n, cpu_hold, done, error, ram_we);
    end
    clear_logs();
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    tests++;
    if (wr_log.size() != 4 || wr_log[0] !== init_exp[0] || wr_log[1] !== init_exp[1] || wr_log[2] !== init_exp[2] || wr_log[3] !== init_exp[3]) begin
      fails++;
      $display("FAIL midreset_init: got %0d init writes, required the 4-write sequence", wr_log.size());
    end
    f = '{8'h55, 8'h02, 8'h00, 8'h00, 8'h10, 8'h34, 8'h12, 8'h78, 8'h56, 8'h26};
    send(f);
    tests++;
    if (done !== 1'b1 || we_cnt != 2 || mem[16'h1001] !== 16'h5678) begin
      fails++;
      $display("FAIL midreset_reload: got done=%b we=%0d ram1001=%h, required 1 2 5678", done, we_cnt, mem[16'h1001]);
    end
  endtask

  task automatic test_ram_strobes();
    tests++;
    if (be_bad || ram_idle_bad) begin
      fails++;
      $display("FAIL ram_strobes: got be_bad=%b idle_bad=%b, required 0 0", be_bad, ram_idle_bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init();
    test_normal_load();
    test_bad_checksum();
    test_zero_len();
    test_addr_wrap();
    test_line_error();
    test_reset_mid_frame();
    test_ram_strobes();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
